// File: rtl/dcache_ctrl.sv
// Miss-handling FSM for the 4-way data cache: stall, dirty-victim writeback, block fill, install, replay.
// Optional hit/miss/writeback statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_rden,
    input  logic        cpu_wren,
    input  logic        cache_hit,
    input  logic        victim_dirty,
    output logic        stall,
    output logic        cache_we,
    output logic        cache_update,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [1:0]  state_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] wb_cnt
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WB      = 2'd1;
    localparam logic [1:0] S_FILL    = 2'd2;
    localparam logic [1:0] S_INSTALL = 2'd3;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       req;

    assign req = cpu_rden | cpu_wren;

    always_comb begin
        stall        = 1'b0;
        cache_we     = 1'b0;
        cache_update = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        state_o      = '0;
        if (!RST) begin
            state_o = state;
            case (state)
                S_IDLE: begin
                    stall    = req & ~cache_hit;
                    cache_we = cpu_wren & cache_hit;
                end
                S_WB: begin
                    stall        = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                S_FILL: begin
                    stall = 1'b1;
                end
                default: begin
                    stall        = 1'b1;
                    cache_update = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && !cache_hit) begin
                        state <= victim_dirty ? S_WB : S_FILL;
                        cnt   <= LAT_M1;
                    end
                end
                S_WB: begin
                    if (cnt == '0) begin
                        cnt   <= LAT_M1;
                        state <= S_FILL;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_FILL: begin
                    if (cnt == '0) begin
                        state <= S_INSTALL;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The replay flag only affects hit accounting, so it lives with the counters.
    logic        replay;
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    logic [31:0] wb_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            replay <= 1'b0;
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                if (cache_hit) begin
                    replay <= 1'b0;
                    if (!replay) begin
                        hit_q <= hit_q + 32'd1;
                    end
                end else begin
                    miss_q <= miss_q + 32'd1;
                end
            end
            if (state == S_WB && cnt == '0) begin
                wb_q <= wb_q + 32'd1;
            end
            if (state == S_INSTALL) begin
                replay <= 1'b1;
            end
        end
    end

    assign hit_cnt  = RST ? '0 : hit_q;
    assign miss_cnt = RST ? '0 : miss_q;
    assign wb_cnt   = RST ? '0 : wb_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl: four instances with MEM_LAT 1..4 checked
// against a timeline model (expected per-cycle phases queued when a miss is accepted).
module tb_dcache_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] rden_v  = '0;
    logic [3:0] wren_v  = '0;
    logic [3:0] hit_v   = '0;
    logic [3:0] dirty_v = '0;
    logic [3:0] stall_v, we_v, upd_v, mwe_v, sel_v;
    logic [1:0] st_v [4];
`ifdef DCACHE_STATS_EN
    logic [31:0] hc_v [4];
    logic [31:0] mc_v [4];
    logic [31:0] wc_v [4];
`endif

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dcache_ctrl #(.MEM_LAT(g + 1)) u_dut (
            .CLK          (CLK),
            .RST          (RST),
            .cpu_rden     (rden_v[g]),
            .cpu_wren     (wren_v[g]),
            .cache_hit    (hit_v[g]),
            .victim_dirty (dirty_v[g]),
            .stall        (stall_v[g]),
            .cache_we     (we_v[g]),
            .cache_update (upd_v[g]),
            .mem_we       (mwe_v[g]),
            .mem_addr_sel (sel_v[g]),
            .state_o      (st_v[g])
`ifdef DCACHE_STATS_EN
            ,
            .hit_cnt      (hc_v[g]),
            .miss_cnt     (mc_v[g]),
            .wb_cnt       (wc_v[g])
`endif
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: pending phases (1=writeback, 2=fill, 3=install), per-lane replay flag and event tallies.
    int          phase_q [$];
    logic [3:0]  replay = '0;
    int unsigned m_hit  [4];
    int unsigned m_miss [4];
    int unsigned m_wb   [4];

    function automatic logic [6:0] outs(input int l);
        return {stall_v[l], we_v[l], upd_v[l], mwe_v[l], sel_v[l], st_v[l]};
    endfunction

    task automatic model_clear();
        phase_q.delete();
        replay = '0;
        for (int i = 0; i < 4; i++) begin
            m_hit[i] = 0; m_miss[i] = 0; m_wb[i] = 0;
        end
    endtask

    task automatic check_counters(input int l);
`ifdef DCACHE_STATS_EN
        check("hit_cnt",  hc_v[l], m_hit[l]);
        check("miss_cnt", mc_v[l], m_miss[l]);
        check("wb_cnt",   wc_v[l], m_wb[l]);
`endif
    endtask

    // One clock cycle on lane l: drive, compare against model just before the edge, advance.
    task automatic step(input int l, input logic rd, input logic wr, input logic hit, input logic dirty);
        logic [6:0] exp;
        logic [1:0] ph;
        logic       req;
        rden_v = '0; wren_v = '0; hit_v = '0; dirty_v = '0;
        rden_v[l] = rd; wren_v[l] = wr; hit_v[l] = hit; dirty_v[l] = dirty;
        #2;
        if (phase_q.size() == 0) check_counters(l);
        if (phase_q.size() > 0) begin
            ph  = 2'(phase_q.pop_front());
            exp = {1'b1, 1'b0, ph == 2'd3, ph == 2'd1, ph == 2'd1, ph};
            if (ph == 2'd3) replay[l] = 1'b1;
        end else begin
            req = rd | wr;
            exp = {req & ~hit, wr & hit, 3'b000, 2'd0};
            if (req && hit) begin
                if (!replay[l]) m_hit[l]++;
                replay[l] = 1'b0;
            end else if (req) begin
                m_miss[l]++;
                if (dirty) begin
                    m_wb[l]++;
                    for (int k = 0; k <= l; k++) phase_q.push_back(1);
                end
                for (int k = 0; k <= l; k++) phase_q.push_back(2);
                phase_q.push_back(3);
            end
        end
        check($sformatf("outs_l%0d", l), 32'(outs(l)), 32'(exp));
        @(posedge CLK);
        #1;
    endtask

    // One cycle with reset asserted; inputs are left as they are to show the outputs are gated.
    task automatic reset_cycle();
        RST = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_outs_l%0d", i), 32'(outs(i)), 32'd0);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_clear();
    endtask

    int          lane;
    logic        c_rd, c_wr, c_hit, c_dirty;
    int unsigned r;

    initial begin
        model_clear();
        #1;
        reset_cycle();
        for (int i = 0; i < 4; i++) check_counters(i);

        // Load hit, MEM_LAT=1
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Clean load miss, MEM_LAT=3, replay raised after install
        step(2, 1, 0, 0, 0);
        repeat (4) step(2, 1, 0, 0, 0);
        step(2, 1, 0, 1, 0);
        step(2, 0, 0, 0, 0);

        // Dirty store miss, MEM_LAT=2
        step(1, 0, 1, 0, 1);
        repeat (5) step(1, 0, 1, 0, 1);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);

        // Request withdrawn during fill, MEM_LAT=3
        step(2, 1, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        repeat (3) step(2, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0);

        // Reset in the 2nd writeback cycle, MEM_LAT=4
        step(3, 1, 0, 0, 1);
        step(3, 1, 0, 0, 1);
        reset_cycle();
        step(3, 0, 0, 0, 0);

        // Simultaneous rden/wren hit
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Randomized traffic across all four latencies
        lane = 0;
        c_rd = 0; c_wr = 0; c_hit = 0; c_dirty = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (phase_q.size() == 0 && !replay[lane] && $urandom_range(0, 39) == 0) begin
                lane = int'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 199) == 0) begin
                reset_cycle();
                continue;
            end
            if (phase_q.size() > 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    c_rd = 0; c_wr = 0;
                end
                c_hit   = 1'($urandom);
                c_dirty = 1'($urandom);
            end else if (replay[lane] && (c_rd || c_wr)) begin
                c_hit = 1'b1;
            end else begin
                r       = $urandom_range(0, 3);
                c_rd    = r[0];
                c_wr    = r[1];
                c_hit   = 1'($urandom);
                c_dirty = 1'($urandom);
            end
            step(lane, c_rd, c_wr, c_hit, c_dirty);
        end
        while (phase_q.size() > 0) step(lane, 0, 0, 0, 0);
        step(lane, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Miss-handling state machine for the 4-way set-associative data cache and its block-wide backing memory. Sits between the CPU memory stage and the cache/memory pair: it detects misses, stalls the pipeline, sequences dirty-victim writeback and block fill, pulses the cache install, and replays the stalled access as a hit. It contains no data storage; the data and address paths stay in the cache and memory.

## Interface
- `MEM_LAT`, default 1: memory cycles per 4-word block transfer; legal range 1..15.
- `CLK` in 1: clock; all state changes on posedge.
- `RST` in 1: synchronous, active-high reset.
- `cpu_rden` in 1: CPU load request, held until `stall` is low.
- `cpu_wren` in 1: CPU store request, held until `stall` is low.
- `cache_hit` in 1: combinational hit for the current CPU address.
- `victim_dirty` in 1: dirty bit of the LRU way in the addressed set (ungated).
- `stall` out 1: freeze the pipeline.
- `cache_we` out 1: commit store data into the hit way.
- `cache_update` out 1: install fetched block into the LRU way (1-cycle pulse).
- `mem_we` out 1: block write enable to memory.
- `mem_addr_sel` out 1: 0 = CPU block address; 1 = victim writeback address.
- `state_o` out 2: current state (IDLE=0, WB=1, FILL=2, INSTALL=3).
- `hit_cnt`, `miss_cnt`, `wb_cnt` out 32 each: present only with `DCACHE_STATS_EN`.

## Operation
- `req = cpu_rden | cpu_wren`. Both high is treated as a store.
- **IDLE**
  - `!req`: all outputs 0.
  - `req & cache_hit`: `stall`=0. For a store, `cache_we`=1 this cycle. Stay in IDLE; clear `replay`.
  - `req & !cache_hit`: `stall`=1. Go to WB if `victim_dirty`, else FILL. Load the 4-bit counter `cnt` with `MEM_LAT-1`.
- **WB**: `stall`=1, `mem_addr_sel`=1, `mem_we`=1. Decrement `cnt`. When `cnt`==0, reload it with `MEM_LAT-1` and go to FILL.
- **FILL**: `stall`=1, `mem_addr_sel`=0, `mem_we`=0. Decrement `cnt`. When `cnt`==0, go to INSTALL.
- **INSTALL**: `stall`=1, `cache_update`=1 for exactly this cycle. Set `replay`, then go to IDLE.
- **Replay**: the IDLE cycle after INSTALL must see a hit. It completes the access (store: `cache_we`=1) and is not counted as a hit.
- If `req` drops during WB/FILL/INSTALL, the sequence still runs to IDLE; the installed block stays valid.
- All outputs are Moore-decoded from state, except IDLE `stall`/`cache_we`, which are combinational on `req`/`cache_hit`.
- **Reset**: while `RST`=1, all outputs are forced to 0, combinationally gated. On the sampling edge: state→IDLE, `cnt`=0, `replay`=0, counters=0. Reset during WB aborts the writeback; memory content is undefined for that block.

## Timing
- **Hit**: 0 stall cycles; store commits in the request cycle (cache writes on negedge).
- **Clean miss**:
  - Miss cycle `t`: stall=1.
  - FILL: `t+1..t+MEM_LAT`.
  - INSTALL: `t+MEM_LAT+1`.
  - Replay hit: `t+MEM_LAT+2`, stall=0.
  - Total: `MEM_LAT+2` stall cycles.
- **Dirty miss**: adds `MEM_LAT` WB cycles before FILL. Total `2*MEM_LAT+2` stall cycles.
- `mem_we` high for exactly `MEM_LAT` consecutive cycles per writeback.
- `cache_update` is never high in the same cycle as `mem_we` or `cache_we`.
- Back-to-back misses: a new miss is detected in the first IDLE cycle after a replay; no idle bubble is inserted.

## Configuration
- `DCACHE_STATS_EN` defined: 32-bit wrapping counters and ports are present.
  - `hit_cnt` +1 per non-replay IDLE hit with `req`.
  - `miss_cnt` +1 per IDLE→WB/FILL transition.
  - `wb_cnt` +1 per WB→FILL transition.
  - All counters clear on `RST`.
- Undefined: the counters and the three ports do not exist; FSM behaviour is identical.

## Test plan
- **Load hit**: `MEM_LAT`=1, `cpu_rden`=1, `cache_hit`=1 → `stall`=0, no `cache_update`/`mem_we`; `hit_cnt` 0→1.
- **Clean load miss**: `MEM_LAT`=3, `cache_hit`=0, `victim_dirty`=0 → `stall` high 5 cycles, `state_o` 0,2,2,2,3,0, `cache_update` at cycle 4 only; bench raises `cache_hit` after install; replay not counted (`hit_cnt`=0, `miss_cnt`=1).
- **Dirty store miss**: `MEM_LAT`=2, `cpu_wren`=1, `victim_dirty`=1 → `mem_we`=1 with `mem_addr_sel`=1 for 2 cycles, then 2 FILL cycles, INSTALL, then replay with `cache_we`=1; 6 stall cycles; `wb_cnt`=1.
- **Request withdrawn**: drop `cpu_rden` during FILL → FSM still reaches INSTALL and IDLE; `cache_update` pulses once.
- **Reset mid-writeback**: assert `RST` in the 2nd WB cycle (`MEM_LAT`=4) → `mem_we`=0 that cycle, `state_o`=0 next cycle, all counters 0.
- **Simultaneous rden/wren hit**: both=1, `cache_hit`=1 → `cache_we`=1, `stall`=0.
